// File: rtl/me_pixel_feeder.sv
// Motion-estimation pixel feeder: fetches the current-block rows, then the reference rows,
// and routes the in-order read responses to the search engine's current/reference inputs.
module me_pixel_feeder #(
    parameter int unsigned CUR_BEATS   = 16,
    parameter int unsigned REF_BEATS   = 64,
    parameter int unsigned LINE_STRIDE = 64,
    parameter int unsigned MAX_OUTST   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [19:0]  base_cur_addr,
    input  logic [19:0]  base_ref_addr,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic [19:0]  mem_req_addr,
    input  logic         mem_rsp_valid,
    input  logic [511:0] mem_rsp_data,
    output logic [511:0] current_64pixels,
    output logic         cur_valid,
    output logic [255:0] ref_input,
    output logic         ref_valid,
    output logic         busy,
    output logic         done
);

    localparam int unsigned TotalBeats = CUR_BEATS + REF_BEATS;
    localparam int unsigned CntW       = $clog2(TotalBeats + 1);
    localparam int unsigned OutW       = $clog2(MAX_OUTST + 1);

    localparam logic [CntW-1:0] CurLast  = CntW'(CUR_BEATS - 1);
    localparam logic [CntW-1:0] RefLast  = CntW'(REF_BEATS - 1);
    localparam logic [CntW-1:0] CurCnt   = CntW'(CUR_BEATS);
    localparam logic [CntW-1:0] TotalCnt = CntW'(TotalBeats);
    localparam logic [OutW-1:0] OutMax   = OutW'(MAX_OUTST);
    localparam logic [19:0]     Stride   = 20'(LINE_STRIDE);

    typedef enum logic [2:0] {StIdle, StCur, StRef, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] req_cnt_q, req_cnt_d;
    logic [CntW-1:0] rcv_cnt_q, rcv_cnt_d;
    logic [OutW-1:0] outst_q, outst_d;
    logic [19:0]     addr_q, addr_d;
    logic [19:0]     ref_base_q, ref_base_d;
    logic            issue;
    logic            rsp_take;
    logic            rsp_dec;
    logic            rsp_is_cur;

    // State register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StCur;
            StCur:   if (issue && req_cnt_q == CurLast) state_d = StRef;
            StRef:   if (issue && req_cnt_q == RefLast) state_d = StDrain;
            StDrain: if (rcv_cnt_q == TotalCnt) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; valid only depends on registered state so it cannot drop while stalled
    always_comb begin
        mem_req_valid = ((state_q == StCur) || (state_q == StRef)) && (outst_q < OutMax);
        busy          = (state_q != StIdle);
        done          = (state_q == StDone);
    end

    assign issue        = mem_req_valid && mem_req_ready;
    assign rsp_take     = mem_rsp_valid &&
                          ((state_q == StCur) || (state_q == StRef) || (state_q == StDrain));
    assign rsp_dec      = rsp_take && (outst_q != '0);
    assign rsp_is_cur   = (rcv_cnt_q < CurCnt);
    assign mem_req_addr = addr_q;

    always_comb begin
        req_cnt_d  = req_cnt_q;
        rcv_cnt_d  = rcv_cnt_q;
        outst_d    = outst_q;
        addr_d     = addr_q;
        ref_base_d = ref_base_q;
        if (state_q == StIdle) begin
            if (start) begin
                req_cnt_d  = '0;
                rcv_cnt_d  = '0;
                outst_d    = '0;
                addr_d     = base_cur_addr;
                ref_base_d = base_ref_addr;
            end
        end else begin
            if (issue) begin
                // Last current row hands the address generator over to the reference base
                if (state_q == StCur && req_cnt_q == CurLast) begin
                    req_cnt_d = '0;
                    addr_d    = ref_base_q;
                end else begin
                    req_cnt_d = req_cnt_q + 1'b1;
                    addr_d    = addr_q + Stride;
                end
            end
            if (rsp_take) begin
                rcv_cnt_d = rcv_cnt_q + 1'b1;
            end
            if (issue && !rsp_dec) begin
                outst_d = outst_q + 1'b1;
            end else if (!issue && rsp_dec) begin
                outst_d = outst_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            req_cnt_q  <= '0;
            rcv_cnt_q  <= '0;
            outst_q    <= '0;
            addr_q     <= '0;
            ref_base_q <= '0;
        end else begin
            req_cnt_q  <= req_cnt_d;
            rcv_cnt_q  <= rcv_cnt_d;
            outst_q    <= outst_d;
            addr_q     <= addr_d;
            ref_base_q <= ref_base_d;
        end
    end

    // Response routing: first CUR_BEATS beats feed the current path, the rest the reference path
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cur_valid        <= 1'b0;
            ref_valid        <= 1'b0;
            current_64pixels <= '0;
            ref_input        <= '0;
        end else begin
            cur_valid <= rsp_take && rsp_is_cur;
            ref_valid <= rsp_take && !rsp_is_cur;
            if (rsp_take && rsp_is_cur) begin
                current_64pixels <= mem_rsp_data;
            end
            if (rsp_take && !rsp_is_cur) begin
                ref_input <= mem_rsp_data[255:0];
            end
        end
    end

endmodule

// File: tb/tb_me_pixel_feeder.sv
// Self-checking bench for me_pixel_feeder: randomized in-order memory model plus a
// transaction-level reference model of the expected address list and beat routing.
module tb_me_pixel_feeder;

    localparam int CurBeats = 16;
    localparam int RefBeats = 64;
    localparam int Stride   = 64;
    localparam int MaxOutst = 4;
    localparam int Total    = CurBeats + RefBeats;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [19:0]  base_cur_addr;
    logic [19:0]  base_ref_addr;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [19:0]  mem_req_addr;
    logic         mem_rsp_valid;
    logic [511:0] mem_rsp_data;
    logic [511:0] current_64pixels;
    logic         cur_valid;
    logic [255:0] ref_input;
    logic         ref_valid;
    logic         busy;
    logic         done;

    me_pixel_feeder #(
        .CUR_BEATS  (CurBeats),
        .REF_BEATS  (RefBeats),
        .LINE_STRIDE(Stride),
        .MAX_OUTST  (MaxOutst)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .base_cur_addr   (base_cur_addr),
        .base_ref_addr   (base_ref_addr),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .current_64pixels(current_64pixels),
        .cur_valid       (cur_valid),
        .ref_input       (ref_input),
        .ref_valid       (ref_valid),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] data;
        int           due;
    } rsp_t;

    rsp_t         pend_q[$];
    logic [19:0]  exp_addr[$];
    logic [19:0]  act_addr[$];
    int           checks, errors, cycle;
    int           lat, ready_pct, ready_low, last_due;
    bit           fetching;
    int           post, n_issued, n_beats;
    int           cur_seen, ref_seen, done_seen, max_outst;
    logic [511:0] last_cur;
    logic [255:0] last_ref;

    task automatic model_reset();
        fetching = 1'b0;
        post     = -1;
        last_cur = '0;
        last_ref = '0;
    endtask

    // One clock: model the memory, predict the DUT from the transaction model, compare.
    task automatic step();
        logic         issued, rv, st, in_rst, exp_cv, exp_rv, exp_done, was_fetching;
        logic [19:0]  a, bc, br, want;
        logic [511:0] rd, d;
        rsp_t         e;
        issued = mem_req_valid && mem_req_ready;
        a      = mem_req_addr;
        rv     = mem_rsp_valid;
        rd     = mem_rsp_data;
        st     = start;
        bc     = base_cur_addr;
        br     = base_ref_addr;
        in_rst = rst_n;
        @(posedge clk);
        #1;
        cycle++;
        exp_cv = 1'b0;
        exp_rv = 1'b0;
        if (in_rst) begin
            model_reset();
        end else begin
            was_fetching = fetching;
            if (post >= 0) post++;
            if (rv && fetching) begin
                if (n_beats < CurBeats) begin
                    exp_cv   = 1'b1;
                    last_cur = rd;
                end else begin
                    exp_rv   = 1'b1;
                    last_ref = rd[255:0];
                end
                n_beats++;
                if (n_beats == Total) post = 0;
            end
            if (issued) begin
                want = (n_issued < exp_addr.size()) ? exp_addr[n_issued] : 20'hxxxxx;
                checks++;
                if (!was_fetching || n_issued >= exp_addr.size() || a !== want) begin
                    errors++;
                    $display("FAIL req_addr #%0d: got %h want %h", n_issued, a, want);
                end
                act_addr.push_back(a);
                for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
                d[19:0] = a;
                e.data  = d;
                e.due   = (cycle + lat - 1 > last_due) ? cycle + lat - 1 : last_due;
                last_due = e.due;
                pend_q.push_back(e);
                n_issued++;
                if (pend_q.size() > max_outst) max_outst = pend_q.size();
                checks++;
                if (pend_q.size() > MaxOutst) begin
                    errors++;
                    $display("FAIL outstanding: got %0d want <= %0d", pend_q.size(), MaxOutst);
                end
            end
            if (st && !was_fetching) begin
                fetching = 1'b1;
                n_issued = 0;
                n_beats  = 0;
                post     = -1;
                exp_addr.delete();
                act_addr.delete();
                for (int i = 0; i < CurBeats; i++) exp_addr.push_back(bc + 20'(i * Stride));
                for (int j = 0; j < RefBeats; j++) exp_addr.push_back(br + 20'(j * Stride));
            end
        end
        exp_done = (post == 1);
        if (post == 2) begin
            fetching = 1'b0;
            post     = -1;
        end
        checks++;
        if (cur_valid !== exp_cv || ref_valid !== exp_rv) begin
            errors++;
            $display("FAIL valids @%0d: got cur=%b ref=%b want cur=%b ref=%b",
                     cycle, cur_valid, ref_valid, exp_cv, exp_rv);
        end
        checks++;
        if (current_64pixels !== last_cur) begin
            errors++;
            $display("FAIL cur_data @%0d: got %h want %h", cycle, current_64pixels[63:0],
                     last_cur[63:0]);
        end
        checks++;
        if (ref_input !== last_ref) begin
            errors++;
            $display("FAIL ref_data @%0d: got %h want %h", cycle, ref_input[63:0],
                     last_ref[63:0]);
        end
        checks++;
        if (busy !== fetching || done !== exp_done) begin
            errors++;
            $display("FAIL status @%0d: got busy=%b done=%b want busy=%b done=%b",
                     cycle, busy, done, fetching, exp_done);
        end
        if (cur_valid === 1'b1) cur_seen++;
        if (ref_valid === 1'b1) ref_seen++;
        if (done === 1'b1) done_seen++;
        if (ready_low > 0) begin
            mem_req_ready = 1'b0;
            ready_low--;
        end else begin
            mem_req_ready = (int'($urandom_range(99)) < ready_pct);
        end
        if (pend_q.size() > 0 && pend_q[0].due <= cycle) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = pend_q[0].data;
            void'(pend_q.pop_front());
        end else begin
            mem_rsp_valid = 1'b0;
            for (int i = 0; i < 16; i++) mem_rsp_data[i*32 +: 32] = $urandom;
        end
        start = 1'b0;
    endtask

    task automatic start_fetch(input logic [19:0] bc, input logic [19:0] br);
        base_cur_addr = bc;
        base_ref_addr = br;
        start         = 1'b1;
        cur_seen      = 0;
        ref_seen      = 0;
        done_seen     = 0;
        max_outst     = 0;
        step();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (fetching && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (fetching) begin
            errors++;
            $display("FAIL timeout: fetch not complete after %0d cycles (beats %0d)", budget,
                     n_beats);
            rst_n = 1'b1;
            step();
            rst_n = 1'b0;
            pend_q.delete();
            model_reset();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b1;
        repeat (2) step();
        checks++;
        if ({mem_req_valid, cur_valid, ref_valid, busy, done} !== 5'b0 || mem_req_addr !== '0 ||
            current_64pixels !== '0 || ref_input !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b cv=%b rv=%b busy=%b done=%b addr=%h",
                     mem_req_valid, cur_valid, ref_valid, busy, done, mem_req_addr);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b valid=%b want 0 0", busy, mem_req_valid);
        end
    endtask

    task automatic test_basic();
        lat       = 2;
        ready_pct = 100;
        start_fetch(20'h00100, 20'h08000);
        wait_idle(2000);
        checks++;
        if (cur_seen != 16 || ref_seen != 64 || done_seen != 1) begin
            errors++;
            $display("FAIL basic_counts: got cur=%0d ref=%0d done=%0d want 16 64 1",
                     cur_seen, ref_seen, done_seen);
        end
        checks++;
        if (act_addr.size() != 80 || act_addr[0] !== 20'h00100 || act_addr[15] !== 20'h004C0 ||
            act_addr[16] !== 20'h08000 || act_addr[79] !== 20'h08FC0) begin
            errors++;
            $display("FAIL basic_addrs: got n=%0d first=%h last=%h want 80 00100 08FC0",
                     act_addr.size(), act_addr[0], act_addr[act_addr.size()-1]);
        end
    endtask

    task automatic test_stall();
        logic [19:0] held;
        int          n = 0;
        lat       = 2;
        ready_pct = 100;
        start_fetch(20'h00200, 20'h30000);
        while (n_issued < 5 && n < 100) begin
            step();
            n++;
        end
        mem_req_ready = 1'b0;
        ready_low     = 4;
        held          = mem_req_addr;
        checks++;
        if (held !== 20'h00340) begin
            errors++;
            $display("FAIL stall_addr: got %h want 00340", held);
        end
        repeat (5) begin
            step();
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== held) begin
                errors++;
                $display("FAIL stall_hold: got valid=%b addr=%h want 1 %h", mem_req_valid,
                         mem_req_addr, held);
            end
        end
        wait_idle(2000);
        checks++;
        if (cur_seen != 16 || ref_seen != 64 || n_issued != 80) begin
            errors++;
            $display("FAIL stall_counts: got cur=%0d ref=%0d req=%0d want 16 64 80",
                     cur_seen, ref_seen, n_issued);
        end
    endtask

    task automatic test_latency();
        lat       = 20;
        ready_pct = 100;
        start_fetch(20'($urandom), 20'($urandom));
        wait_idle(5000);
        checks++;
        if (max_outst != MaxOutst || cur_seen != 16 || ref_seen != 64) begin
            errors++;
            $display("FAIL latency: got max_outst=%0d cur=%0d ref=%0d want %0d 16 64",
                     max_outst, cur_seen, ref_seen, MaxOutst);
        end
    endtask

    task automatic test_wrap();
        lat       = 3;
        ready_pct = 100;
        start_fetch(20'h12340, 20'hFFFC0);
        wait_idle(2000);
        checks++;
        if (act_addr.size() != 80 || act_addr[17] !== 20'h00000 ||
            act_addr[79] !== 20'h00F80) begin
            errors++;
            $display("FAIL wrap: got n=%0d second_ref=%h last=%h want 80 00000 00F80",
                     act_addr.size(), act_addr[17], act_addr[act_addr.size()-1]);
        end
    endtask

    task automatic test_ignore();
        rsp_t e;
        int   seen_before;
        int   n = 0;
        lat       = 2;
        ready_pct = 100;
        start_fetch(20'h01000, 20'h02000);
        while (n_issued < 30 && n < 200) begin
            step();
            n++;
        end
        base_cur_addr = 20'h0ABC0;
        base_ref_addr = 20'h0DEF0;
        start         = 1'b1;
        step();
        wait_idle(2000);
        checks++;
        if (cur_seen != 16 || ref_seen != 64 || act_addr.size() != 80 ||
            act_addr[30] !== 20'h02380) begin
            errors++;
            $display("FAIL start_in_ref: got cur=%0d ref=%0d n=%0d addr30=%h want 16 64 80 02380",
                     cur_seen, ref_seen, act_addr.size(), act_addr[30]);
        end
        seen_before = cur_seen + ref_seen;
        repeat (3) begin
            for (int i = 0; i < 16; i++) e.data[i*32 +: 32] = $urandom;
            e.due = 0;
            pend_q.push_back(e);
        end
        repeat (6) step();
        checks++;
        if (cur_seen + ref_seen != seen_before || busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_rsp: got beats=%0d busy=%b want %0d 0", cur_seen + ref_seen,
                     busy, seen_before);
        end
        start_fetch(20'h04000, 20'h05000);
        wait_idle(2000);
        checks++;
        if (cur_seen != 16 || ref_seen != 64) begin
            errors++;
            $display("FAIL after_stray: got cur=%0d ref=%0d want 16 64", cur_seen, ref_seen);
        end
    endtask

    task automatic test_back_to_back();
        lat       = 2;
        ready_pct = 100;
        start_fetch(20'h00040, 20'h00080);
        wait_idle(2000);
        start_fetch(20'h70000, 20'h71000);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_start: got busy=%b want 1", busy);
        end
        wait_idle(2000);
        checks++;
        if (cur_seen != 16 || ref_seen != 64 || done_seen != 1) begin
            errors++;
            $display("FAIL back_to_back: got cur=%0d ref=%0d done=%0d want 16 64 1",
                     cur_seen, ref_seen, done_seen);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        lat       = 4;
        ready_pct = 100;
        start_fetch(20'h00400, 20'h09000);
        while (n_issued < 40 && n < 300) begin
            step();
            n++;
        end
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({mem_req_valid, cur_valid, ref_valid, busy, done} !== 5'b0 || mem_req_addr !== '0 ||
            current_64pixels !== '0 || ref_input !== '0) begin
            errors++;
            $display("FAIL reset_mid: got v=%b cv=%b rv=%b busy=%b done=%b addr=%h",
                     mem_req_valid, cur_valid, ref_valid, busy, done, mem_req_addr);
        end
        model_reset();
        step();
        rst_n = 1'b0;
        n = 0;
        while (pend_q.size() > 0 && n < 100) begin
            step();
            n++;
        end
        step();
        start_fetch(20'h00800, 20'h0A000);
        wait_idle(2000);
        checks++;
        if (cur_seen != 16 || ref_seen != 64 || done_seen != 1) begin
            errors++;
            $display("FAIL after_reset: got cur=%0d ref=%0d done=%0d want 16 64 1",
                     cur_seen, ref_seen, done_seen);
        end
    endtask

    task automatic test_random();
        repeat (3) begin
            lat       = int'($urandom_range(8, 1));
            ready_pct = int'($urandom_range(100, 40));
            start_fetch(20'($urandom), 20'($urandom));
            wait_idle(5000);
            checks++;
            if (cur_seen != 16 || ref_seen != 64 || done_seen != 1) begin
                errors++;
                $display("FAIL random: got cur=%0d ref=%0d done=%0d want 16 64 1",
                         cur_seen, ref_seen, done_seen);
            end
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        cycle         = 0;
        lat           = 2;
        ready_pct     = 100;
        ready_low     = 0;
        last_due      = 0;
        n_issued      = 0;
        n_beats       = 0;
        rst_n         = 1'b1;
        start         = 1'b0;
        base_cur_addr = '0;
        base_ref_addr = '0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        model_reset();
        test_reset();
        test_basic();
        test_stall();
        test_latency();
        test_wrap();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/me_pixel_feeder.md
ME_PIXEL_FEEDER -- requirements
Module: me_pixel_feeder

Interface
REQ-001 Parameter: CUR_BEATS, 16, number of 64-pixel current-block rows fetched per search.
REQ-002 Parameter: REF_BEATS, 64, number of 32-pixel reference rows fetched per search.
REQ-003 Parameter: LINE_STRIDE, 64, address increment between consecutive rows.
REQ-004 Parameter: MAX_OUTST, 4, maximum memory requests in flight.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-high reset (1 = reset) despite the name.
REQ-007 start  input  1  one-cycle search-fetch request.
REQ-008 base_cur_addr  input  20  current-block row 0 address, sampled on accepted start.
REQ-009 base_ref_addr  input  20  reference row 0 address, sampled on accepted start.
REQ-010 mem_req_valid  output  1  memory read request valid.
REQ-011 mem_req_ready  input  1  memory accepts request.
REQ-012 mem_req_addr  output  20  read address.
REQ-013 mem_rsp_valid  input  1  in-order read data valid (no backpressure).
REQ-014 mem_rsp_data  input  512  read data.
REQ-015 current_64pixels  output  512  current-block row to the search engine.
REQ-016 cur_valid  output  1  current_64pixels valid this cycle.
REQ-017 ref_input  output  256  reference row to the search engine.
REQ-018 ref_valid  output  1  ref_input valid this cycle.
REQ-019 busy  output  1  fetch in progress.
REQ-020 done  output  1  one-cycle completion pulse.

Function
REQ-021 FSM states IDLE, CUR, REF, DRAIN, DONE; start accepted only in IDLE, ignored elsewhere.
REQ-022 IDLE -> CUR on start; CUR -> REF after CUR_BEATS requests handshaken; REF -> DRAIN after REF_BEATS requests handshaken; DRAIN -> DONE when received-beat count = CUR_BEATS+REF_BEATS; DONE -> IDLE after one cycle.
REQ-023 Request handshake: issued when mem_req_valid && mem_req_ready; mem_req_addr, mem_req_valid stable while valid && !ready.
REQ-024 mem_req_valid high only in CUR/REF and only when outstanding < MAX_OUTST (registered count).
REQ-025 Outstanding count: +1 on issue, -1 on mem_rsp_valid, unchanged on simultaneous; never below 0.
REQ-026 Addresses: CUR row i = base_cur_addr + i*LINE_STRIDE; REF row j = base_ref_addr + j*LINE_STRIDE; modulo 2^20 (wrap, no error).
REQ-027 Response routing by received-beat counter k: k < CUR_BEATS -> current path, else reference path.
REQ-028 Current path: current_64pixels <= mem_rsp_data, cur_valid = 1 the cycle after mem_rsp_valid (1-cycle latency).
REQ-029 Reference path: ref_input <= mem_rsp_data[255:0], ref_valid = 1 the cycle after mem_rsp_valid; bits [511:256] discarded.
REQ-030 cur_valid and ref_valid never high together; each high one cycle per beat; data outputs hold last value otherwise.
REQ-031 mem_rsp_valid in IDLE is dropped: no valid output, counters unchanged.
REQ-032 busy = 1 in CUR, REF, DRAIN, DONE; done = 1 only in DONE.
REQ-033 Back-to-back: start in the cycle after DONE accepted normally.

Reset
REQ-034 rst_n = 1 immediately forces IDLE, all counters 0, mem_req_valid, cur_valid, ref_valid, busy, done = 0, mem_req_addr, current_64pixels, ref_input = 0.
REQ-035 Reset mid-fetch abandons the fetch; responses arriving after reset in IDLE are dropped per REQ-031.

Verification
REQ-036 start, base_cur=0x00100, base_ref=0x08000, ready always 1, 2-cycle memory -> 16 cur_valid beats addrs 0x00100..0x004C0, then 64 ref_valid beats addrs 0x08000..0x08FC0, one done pulse.
REQ-037 mem_req_ready held 0 for 5 cycles mid-CUR -> mem_req_addr/valid stable, no beat skipped or duplicated.
REQ-038 Memory latency 20 cycles -> never more than 4 requests outstanding; all 80 beats delivered in order.
REQ-039 base_ref=0xFFFC0 -> second ref address 0x00000 (wrap).
REQ-040 start during REF and stray mem_rsp_valid in IDLE -> both ignored, no outputs, beat counts unchanged.
REQ-041 rst_n pulsed during REF -> next cycle all outputs 0, state IDLE; fresh start completes normally.
